// File: rtl/alu_ex_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_stage
//
// Single-register execute stage for a simple ALU. It accepts one
// operand/opcode bundle per cycle through a valid/ready handshake, computes
// the result and its flags combinationally, and registers them into an
// output slot that drains through a second valid/ready handshake.
//
// Parameters
//   XLEN        datapath width in bits (default 32)
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   in_valid    upstream bundle valid
//   in_ready    stage can accept a bundle this cycle
//   operation   4-bit opcode from the ALU control block
//   src_a       first operand
//   src_b       second operand
//   out_valid   registered result bundle valid
//   out_ready   downstream accepts the result bundle this cycle
//   result      registered ALU result
//   zero        registered flag, result is all zeros
//   overflow    registered signed-overflow flag (ADD/SUB only)
//   illegal_op  registered flag, opcode not in the decode table
//   op_count    number of bundles accepted since reset (wraps at 16 bits)
// ---------------------------------------------------------------------------
module alu_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic            illegal_op,
    output logic [15:0]     op_count
);

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_SUB_R  = 4'b0100,
        OP_SUB_BR = 4'b0110
    } alu_op_e;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    logic            out_valid_q;
    logic [XLEN-1:0] result_q,   result_d;
    logic            zero_q,     zero_d;
    logic            overflow_q, overflow_d;
    logic            illegal_q,  illegal_d;
    logic [15:0]     count_q,    count_d;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic accept;

    // The slot is free when empty or being drained this cycle; in_valid is
    // deliberately absent so there is no valid->ready combinational path.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // ALU datapath
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            a_msb;
    logic            b_msb;

    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign a_msb = src_a[XLEN-1];
    assign b_msb = src_b[XLEN-1];

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        case (operation)
            OP_AND: begin
                result_d = src_a & src_b;
            end
            OP_OR: begin
                result_d = src_a | src_b;
            end
            OP_ADD: begin
                result_d   = sum;
                // Same-sign operands producing a different-sign sum.
                overflow_d = (a_msb == b_msb) && (sum[XLEN-1] != a_msb);
            end
            OP_SUB_R, OP_SUB_BR: begin
                result_d   = diff;
                // Opposite-sign operands with the difference flipping sign
                // away from the minuend.
                overflow_d = (a_msb != b_msb) && (diff[XLEN-1] != a_msb);
            end
            default: begin
                result_d  = '0;
                illegal_d = 1'b1;
            end
        endcase
        zero_d = (result_d == '0);
    end

    assign count_d = count_q + 16'd1;

    // -----------------------------------------------------------------------
    // Output slot
    // -----------------------------------------------------------------------
    // Acceptance takes priority over drain so that a simultaneous
    // drain+accept reloads the slot and keeps out_valid high (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                result_q    <= result_d;
                zero_q      <= zero_d;
                overflow_q  <= overflow_d;
                illegal_q   <= illegal_d;
                count_q     <= count_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
    assign illegal_op = illegal_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal_op;
    logic [15:0] op_count;

    int          tests;
    int          fails;
    logic [15:0] exp_cnt;

    alu_ex_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bundle through an empty stage with out_ready high; checks the
    // registered response one cycle later and the drain on the cycle after.
    task automatic run_one(input string name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_z,
                           input logic exp_ov, input logic exp_ill);
        operation = op; src_a = a; src_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        tests++;
        if ({out_valid, result, zero, overflow, illegal_op, op_count} !==
            {1'b1, exp_res, exp_z, exp_ov, exp_ill, exp_cnt}) begin
            fails++;
            $display("FAIL %s: got v=%b res=%h z=%b ov=%b ill=%b cnt=%h, want v=1 res=%h z=%b ov=%b ill=%b cnt=%h",
                     name, out_valid, result, zero, overflow, illegal_op, op_count,
                     exp_res, exp_z, exp_ov, exp_ill, exp_cnt);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: out_valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operation = 4'b0010; src_a = 32'h1; src_b = 32'h1;
        #3;
        tests++;
        if ({out_valid, result, zero, overflow, illegal_op, op_count, in_ready} !==
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: v=%b res=%h z=%b ov=%b ill=%b cnt=%h rdy=%b, want 0/0/0/0/0/0/1",
                     out_valid, result, zero, overflow, illegal_op, op_count, in_ready);
        end
        // An edge during reset with in_valid high must not accept.
        in_valid = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || op_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_no_accept: v=%b cnt=%h want 0/0000", out_valid, op_count);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        exp_cnt = 16'h0;
    endtask

    task automatic test_add();
        run_one("add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_one("add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_one("add_negov", 4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_one("sub_br_eq", 4'b0110, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_one("sub_r_eq",  4'b0100, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_one("sub_ovf",   4'b0100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        run_one("sub_neg",   4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_ovf2",  4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_logic_illegal();
        run_one("and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        run_one("or",      4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        run_one("ill_f",   4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_one("ill_3",   4'b0011, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_one("ill_5",   4'b0101, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    endtask

    // Unaccepted inputs must not disturb the held registers.
    task automatic test_ignore();
        run_one("pre_ign", 4'b0001, 32'h00A00000, 32'h0000000B, 32'h00A0000B, 1'b0, 1'b0, 1'b0);
        operation = 4'b1111; src_a = 32'hDEADBEEF; src_b = 32'h0;
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        tests++;
        if ({out_valid, result, zero, illegal_op, op_count} !==
            {1'b0, 32'h00A0000B, 1'b0, 1'b0, exp_cnt}) begin
            fails++;
            $display("FAIL ignore: v=%b res=%h z=%b ill=%b cnt=%h want 0/00a0000b/0/0/%h",
                     out_valid, result, zero, illegal_op, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = exp_cnt;
        out_ready = 1'b0;
        operation = 4'b0000; src_a = 32'hF0F0F0F0; src_b = 32'hFF00FF00;
        in_valid = 1'b1;
        step();
        // Second bundle presented while the first is stalled.
        operation = 4'b0001; src_a = 32'h0000000F; src_b = 32'h000000F0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({out_valid, result, zero, overflow, illegal_op, in_ready, op_count} !==
                {1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, base + 16'd1}) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b res=%h z=%b ov=%b ill=%b rdy=%b cnt=%h want 1/f000f000/0/0/0/0/%h",
                         i, out_valid, result, zero, overflow, illegal_op, in_ready, op_count,
                         base + 16'd1);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_comb: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, result, op_count} !== {1'b1, 32'h000000FF, base + 16'd2}) begin
            fails++;
            $display("FAIL bp_second: v=%b res=%h cnt=%h want 1/000000ff/%h",
                     out_valid, result, op_count, base + 16'd2);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || op_count !== base + 16'd2) begin
            fails++;
            $display("FAIL bp_drain: v=%b cnt=%h want 0/%h", out_valid, op_count, base + 16'd2);
        end
        exp_cnt = base + 16'd2;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        operation = 4'b0010; src_a = 32'h00000003; src_b = 32'h00000004;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 32'h00000007) begin
            fails++;
            $display("FAIL rmid_pre: v=%b res=%h want 1/00000007", out_valid, result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, result, op_count, in_ready} !== {1'b0, 32'h0, 16'h0, 1'b1}) begin
            fails++;
            $display("FAIL rmid_async: v=%b res=%h cnt=%h rdy=%b want 0/0/0000/1",
                     out_valid, result, op_count, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 16'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'h0) begin
                fails++;
                $display("FAIL rmid_idle%0d: v=%b rdy=%b cnt=%h want 0/1/0000",
                         i, out_valid, in_ready, op_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res;
        logic [15:0] exp_c;
        int          shown;
        shown = 0;
        operation = 4'b0010; src_b = 32'h1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            src_a = i;
            step();
            exp_res = i + 1;
            exp_c = exp_cnt + 16'(i + 1);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp_res || op_count !== exp_c) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL b2b[%0d]: v=%b rdy=%b res=%h cnt=%h want 1/1/%h/%h",
                             i, out_valid, in_ready, result, op_count, exp_res, exp_c);
                end
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || op_count !== 16'h0001) begin
            fails++;
            $display("FAIL b2b_final: v=%b cnt=%h want 0/0001", out_valid, op_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 16'h0;
        test_reset();
        test_add();
        test_sub();
        test_logic_illegal();
        test_ignore();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream operand/opcode bundle valid.
REQ-005 SHALL have port in_ready, output, 1, stage can accept a bundle this cycle.
REQ-006 SHALL have port operation, input, 4, opcode produced by the ALU control block.
REQ-007 SHALL have port src_a, input, XLEN, first operand.
REQ-008 SHALL have port src_b, input, XLEN, second operand.
REQ-009 SHALL have port out_valid, output, 1, registered result bundle valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the bundle this cycle.
REQ-011 SHALL have port result, output, XLEN, registered ALU result.
REQ-012 SHALL have port zero, output, 1, registered flag, result equals 0.
REQ-013 SHALL have port overflow, output, 1, registered signed-overflow flag for add/subtract.
REQ-014 SHALL have port illegal_op, output, 1, registered flag, opcode not in the decode table.
REQ-015 SHALL have port op_count, output, 16, count of bundles accepted since reset.

Function
REQ-016 SHALL decode operation as: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (branch compare); 0100 SUB (R-type); every other code gives result 0 and illegal_op 1.
REQ-017 SHALL compute ADD/SUB modulo 2^XLEN; carry out of MSB discarded.
REQ-018 SHALL set overflow for ADD when operand signs match and result sign differs; for SUB when operand signs differ and result sign differs from src_a; 0 for AND, OR, illegal.
REQ-019 SHALL set zero to 1 exactly when the registered result is all zeros, including illegal opcodes (result 0 -> zero 1).
REQ-020 SHALL transfer an input bundle only on a clk edge with in_valid and in_ready both 1.
REQ-021 SHALL drive in_ready = (!out_valid) | out_ready, combinationally; no combinational path from in_valid to in_ready.
REQ-022 SHALL present an accepted bundle's result and flags with latency one cycle: out_valid 1 on the edge after acceptance.
REQ-023 SHALL hold result, zero, overflow, illegal_op stable while out_valid 1 and out_ready 0.
REQ-024 SHALL clear out_valid on an edge where out_ready 1 and no new bundle is accepted.
REQ-025 SHALL, on simultaneous output drain and input acceptance, load the new bundle and keep out_valid 1 with no bubble (full throughput, one bundle per cycle).
REQ-026 SHALL ignore src_a, src_b, operation when the bundle is not accepted; output registers keep prior values.
REQ-027 SHALL increment op_count by 1 per accepted bundle, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL never drop or duplicate a bundle: each accepted bundle appears exactly once with out_valid & out_ready.

Reset
REQ-029 SHALL, on rst_n low, immediately (without clk) force out_valid 0, result 0, zero 0, overflow 0, illegal_op 0, op_count 0.
REQ-030 SHALL drive in_ready 1 while in reset and on the first cycle after release.
REQ-031 SHALL discard any bundle held in the output register when reset asserts mid-operation; no bundle emitted after release until a new acceptance.
REQ-032 SHALL accept no bundle on a clk edge where rst_n is low.

Verification
REQ-033 SHALL pass: op 0010, A=0x7FFFFFFF, B=1, out_ready 1 -> next cycle result 0x80000000, overflow 1, zero 0.
REQ-034 SHALL pass: op 0110, A=B=0x12345678 -> result 0, zero 1, overflow 0; repeat with op 0100, identical response.
REQ-035 SHALL pass: op 1111, A=0xFFFFFFFF, B=0xFFFFFFFF -> result 0, illegal_op 1, zero 1, overflow 0.
REQ-036 SHALL pass: back-to-back AND (0xF0F0F0F0 & 0xFF00FF00 = 0xF000F000) then OR (0x0F | 0xF0 = 0xFF) with out_ready held 0 for 3 cycles -> first result held, in_ready 0, second accepted only on drain cycle, both emitted in order, op_count 2.
REQ-037 SHALL pass: accept a bundle, assert rst_n low mid-cycle before drain -> out_valid 0 and op_count 0 immediately; after release no output until new in_valid.
REQ-038 SHALL pass: 65537 accepted bundles with continuous in_valid/out_ready -> one result per cycle, op_count ends at 0x0001.
